// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: load/store op codes,
// FSM state encoding, data-bus size encoding and the bus request record.
package mem_access_unit_pkg;

  localparam logic [7:0] OP_LD_B  = 8'h20;
  localparam logic [7:0] OP_LD_H  = 8'h21;
  localparam logic [7:0] OP_LD_W  = 8'h23;
  localparam logic [7:0] OP_LD_BU = 8'h24;
  localparam logic [7:0] OP_LD_HU = 8'h25;
  localparam logic [7:0] OP_ST_B  = 8'h28;
  localparam logic [7:0] OP_ST_H  = 8'h29;
  localparam logic [7:0] OP_ST_W  = 8'h2B;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } dbus_fmt_t;

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load result formatting: pick the addressed lane out of the bus word and
// sign- or zero-extend it according to the load op.
module mem_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [7:0]  op,
  output logic [31:0] result
);

  logic [31:0] lane;

  assign lane = rdata >> {addr, 3'b000};

  always_comb begin
    case (op)
      OP_LD_B:  result = {{24{lane[7]}}, lane[7:0]};
      OP_LD_BU: result = {24'h0, lane[7:0]};
      OP_LD_H:  result = {{16{lane[15]}}, lane[15:0]};
      OP_LD_HU: result = {16'h0, lane[15:0]};
      default:  result = lane;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues the data-bus handshake, formats store
// data and load results, and stalls the pipeline until the access completes.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall_wb,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic        mem_inst_valid,
  input  logic [31:0] mem_inst_pc,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  input  logic [1:0]  mem_excepttype,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [1:0]  dbus_size,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_wstrb,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_addr_ok,
  input  logic        dbus_data_ok,
  input  logic [31:0] dbus_rdata,
  output logic        stallreq_mem,
  output logic        ale_o,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        wb_inst_valid,
  output logic [31:0] wb_inst_pc
);

  logic [2:0]  state, state_nxt;
  logic [31:0] result_q, load_val;
  logic        is_load, is_store, is_byte, is_half, is_word;
  logic        chk, ale, mem_op, latch;
  logic [1:0]  a;
  dbus_fmt_t   fmt;

  assign a        = mem_mem_addr[1:0];
  assign is_load  = mem_aluop inside {OP_LD_B, OP_LD_H, OP_LD_W, OP_LD_BU, OP_LD_HU};
  assign is_store = mem_aluop inside {OP_ST_B, OP_ST_H, OP_ST_W};
  assign is_byte  = mem_aluop inside {OP_LD_B, OP_LD_BU, OP_ST_B};
  assign is_half  = mem_aluop inside {OP_LD_H, OP_LD_HU, OP_ST_H};
  assign is_word  = mem_aluop inside {OP_LD_W, OP_ST_W};

  // Only accesses that would otherwise be issued are alignment-checked.
  assign chk    = mem_inst_valid && (mem_excepttype == 2'b00) && (is_load || is_store);
  assign ale    = ALIGN_CHECK && chk && ((is_half && a[0]) || (is_word && (a != 2'b00)));
  assign mem_op = chk && !ale;

  always_comb begin
    fmt.we    = is_store;
    fmt.size  = is_byte ? SZ_BYTE : (is_half ? SZ_HALF : SZ_WORD);
    fmt.wstrb = 4'b0000;
    fmt.wdata = mem_reg2;
    if (is_store && !ale) begin
      case (mem_aluop)
        OP_ST_B: fmt.wstrb = 4'b0001 << a;
        OP_ST_H: fmt.wstrb = 4'b0011 << a;
        default: fmt.wstrb = 4'b1111;
      endcase
    end
    case (mem_aluop)
      OP_ST_B: fmt.wdata = {4{mem_reg2[7:0]}};
      OP_ST_H: fmt.wdata = {2{mem_reg2[15:0]}};
      default: fmt.wdata = mem_reg2;
    endcase
  end

  mem_load_align u_align (
    .rdata  (dbus_rdata),
    .addr   (a),
    .op     (mem_aluop),
    .result (load_val)
  );

  always_comb begin
    state_nxt    = state;
    dbus_req     = 1'b0;
    stallreq_mem = 1'b0;
    latch        = 1'b0;
    case (state)
      S_IDLE, S_REQ: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (mem_op || state == S_REQ) begin
          dbus_req     = 1'b1;
          stallreq_mem = 1'b1;
          // data_ok may arrive alongside addr_ok; skip WAIT in that case.
          if (dbus_addr_ok && dbus_data_ok) begin
            latch     = 1'b1;
            state_nxt = S_DONE;
          end else if (dbus_addr_ok) begin
            state_nxt = S_WAIT;
          end else begin
            state_nxt = S_REQ;
          end
        end
      end
      S_WAIT: begin
        stallreq_mem = 1'b1;
        if (flush)             state_nxt = dbus_data_ok ? S_IDLE : S_DRAIN;
        else if (dbus_data_ok) begin
          latch     = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  if (flush || !stall_wb) state_nxt = S_IDLE;
      S_DRAIN: begin
        stallreq_mem = mem_op;
        if (dbus_data_ok) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      result_q <= 32'h0;
    end else begin
      state <= state_nxt;
      if (latch) result_q <= load_val;
    end
  end

  assign dbus_we    = fmt.we;
  assign dbus_size  = fmt.size;
  assign dbus_addr  = mem_mem_addr;
  assign dbus_wstrb = fmt.wstrb;
  assign dbus_wdata = fmt.wdata;
  assign ale_o      = ale;

  assign wb_wd         = mem_wd;
  assign wb_wreg       = mem_wreg && mem_inst_valid && !is_store && !ale;
  assign wb_wdata      = (state == S_DONE && is_load) ? result_q : mem_wdata;
  assign wb_inst_valid = mem_inst_valid;
  assign wb_inst_pc    = mem_inst_pc;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a table of single-cycle issue vectors
// checked in IDLE, then clocked sequences for the multi-cycle corner cases.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, stall_wb;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_inst_valid;
  logic [31:0] mem_wdata, mem_inst_pc, mem_mem_addr, mem_reg2;
  logic [7:0]  mem_aluop;
  logic [1:0]  mem_excepttype;
  logic        dbus_req, dbus_we, dbus_addr_ok, dbus_data_ok;
  logic [1:0]  dbus_size;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_wstrb;
  logic        stallreq_mem, ale_o;
  logic [4:0]  wb_wd;
  logic        wb_wreg, wb_inst_valid;
  logic [31:0] wb_wdata, wb_inst_pc;

  int tests = 0;
  int fails = 0;

  mem_access_unit #(.ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_wb(stall_wb),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_inst_valid(mem_inst_valid), .mem_inst_pc(mem_inst_pc),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .mem_excepttype(mem_excepttype),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_size(dbus_size),
    .dbus_addr(dbus_addr), .dbus_wstrb(dbus_wstrb), .dbus_wdata(dbus_wdata),
    .dbus_addr_ok(dbus_addr_ok), .dbus_data_ok(dbus_data_ok), .dbus_rdata(dbus_rdata),
    .stallreq_mem(stallreq_mem), .ale_o(ale_o),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_inst_valid(wb_inst_valid), .wb_inst_pc(wb_inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [1:0]  exc;
    logic        valid;
    logic        wreg;
    logic        fl;
    logic        e_req;
    logic        e_we;
    logic [1:0]  e_size;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic        e_stall;
    logic        e_ale;
    logic        e_wreg;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    mem_inst_valid = 1'b0;
    mem_aluop      = 8'h00;
    mem_wreg       = 1'b0;
    flush          = 1'b0;
    dbus_addr_ok   = 1'b0;
    dbus_data_ok   = 1'b0;
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] addr);
    mem_inst_valid = 1'b1;
    mem_wreg       = 1'b1;
    mem_excepttype = 2'b00;
    mem_aluop      = op;
    mem_mem_addr   = addr;
  endtask

  initial begin
    int sc, rc;
    vecs[0]  = '{8'h01,    32'h0000_0003, 32'h1111_2222, 2'b00, 1'b1, 1'b1, 1'b0,
                 1'b0, 1'b0, SZ_WORD, 4'b0000, 32'h1111_2222, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{OP_ST_H,  32'h0000_2002, 32'h1234_ABCD, 2'b00, 1'b1, 1'b1, 1'b0,
                 1'b1, 1'b1, SZ_HALF, 4'b1100, 32'hABCD_ABCD, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{OP_ST_B,  32'h0000_2001, 32'h0000_00C3, 2'b00, 1'b1, 1'b1, 1'b0,
                 1'b1, 1'b1, SZ_BYTE, 4'b0010, 32'hC3C3_C3C3, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{OP_ST_W,  32'h0000_2000, 32'h1122_3344, 2'b00, 1'b1, 1'b1, 1'b0,
                 1'b1, 1'b1, SZ_WORD, 4'b1111, 32'h1122_3344, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{OP_LD_W,  32'h0000_1002, 32'h0000_0000, 2'b00, 1'b1, 1'b1, 1'b0,
                 1'b0, 1'b0, SZ_WORD, 4'b0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{OP_LD_H,  32'h0000_1001, 32'h0000_0000, 2'b00, 1'b1, 1'b1, 1'b0,
                 1'b0, 1'b0, SZ_HALF, 4'b0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{OP_ST_W,  32'h0000_2001, 32'h0000_0055, 2'b00, 1'b1, 1'b1, 1'b0,
                 1'b0, 1'b1, SZ_WORD, 4'b0000, 32'h0000_0055, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{OP_LD_W,  32'h0000_1000, 32'h0000_0000, 2'b01, 1'b1, 1'b1, 1'b0,
                 1'b0, 1'b0, SZ_WORD, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{OP_LD_W,  32'h0000_1000, 32'h0000_0000, 2'b00, 1'b0, 1'b1, 1'b0,
                 1'b0, 1'b0, SZ_WORD, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{OP_LD_BU, 32'h0000_1003, 32'h0000_0000, 2'b00, 1'b1, 1'b1, 1'b0,
                 1'b1, 1'b0, SZ_BYTE, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{OP_LD_H,  32'h0000_1002, 32'h0000_0000, 2'b00, 1'b1, 1'b1, 1'b1,
                 1'b0, 1'b0, SZ_HALF, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{OP_ST_H,  32'h0000_2000, 32'hFFFF_8001, 2'b00, 1'b1, 1'b1, 1'b0,
                 1'b1, 1'b1, SZ_HALF, 4'b0011, 32'h8001_8001, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; stall_wb = 1'b0; mem_wd = 5'd7; mem_wdata = 32'h5A5A_0001;
    mem_inst_pc = 32'h0040_0100; mem_reg2 = 32'h0; mem_mem_addr = 32'h0;
    mem_excepttype = 2'b00; dbus_rdata = 32'h0;
    nop();
    tick(); tick();
    chk("reset_req", {31'h0, dbus_req}, 32'h0);
    chk("reset_stall", {31'h0, stallreq_mem}, 32'h0);
    chk("reset_ale", {31'h0, ale_o}, 32'h0);
    rst = 1'b0;

    // Vectors are applied and withdrawn between edges so the FSM stays in IDLE.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      mem_aluop = vecs[i].op; mem_mem_addr = vecs[i].addr; mem_reg2 = vecs[i].reg2;
      mem_excepttype = vecs[i].exc; mem_inst_valid = vecs[i].valid;
      mem_wreg = vecs[i].wreg; flush = vecs[i].fl;
      #1;
      chk($sformatf("v%0d_req", i),   {31'h0, dbus_req},     {31'h0, vecs[i].e_req});
      chk($sformatf("v%0d_we", i),    {31'h0, dbus_we},      {31'h0, vecs[i].e_we});
      chk($sformatf("v%0d_size", i),  {30'h0, dbus_size},    {30'h0, vecs[i].e_size});
      chk($sformatf("v%0d_wstrb", i), {28'h0, dbus_wstrb},   {28'h0, vecs[i].e_wstrb});
      chk($sformatf("v%0d_wdata", i), dbus_wdata,            vecs[i].e_wdata);
      chk($sformatf("v%0d_stall", i), {31'h0, stallreq_mem}, {31'h0, vecs[i].e_stall});
      chk($sformatf("v%0d_ale", i),   {31'h0, ale_o},        {31'h0, vecs[i].e_ale});
      chk($sformatf("v%0d_wreg", i),  {31'h0, wb_wreg},      {31'h0, vecs[i].e_wreg});
      chk($sformatf("v%0d_wbdata", i), wb_wdata,             32'h5A5A_0001);
      chk($sformatf("v%0d_addr", i),  dbus_addr,             vecs[i].addr);
      nop();
    end
    mem_excepttype = 2'b00;

    // LD_B, zero-wait slave: two stall cycles, sign-extended top byte.
    tick();
    sc = 0;
    issue(OP_LD_B, 32'h0000_1003); dbus_addr_ok = 1'b1;
    #1;
    chk("ldb_req0", {31'h0, dbus_req}, 32'h1);
    sc += int'(stallreq_mem);
    tick();
    dbus_addr_ok = 1'b0; dbus_data_ok = 1'b1; dbus_rdata = 32'h80AA_5511;
    #1;
    chk("ldb_req_wait", {31'h0, dbus_req}, 32'h0);
    sc += int'(stallreq_mem);
    tick();
    dbus_data_ok = 1'b0; dbus_rdata = 32'h0; stall_wb = 1'b1;
    #1;
    chk("ldb_stall_cycles", sc, 2);
    chk("ldb_done_stall", {31'h0, stallreq_mem}, 32'h0);
    chk("ldb_wdata", wb_wdata, 32'hFFFF_FF80);
    chk("ldb_wreg", {31'h0, wb_wreg}, 32'h1);
    tick();
    chk("ldb_hold_wdata", wb_wdata, 32'hFFFF_FF80);
    chk("ldb_hold_stall", {31'h0, stallreq_mem}, 32'h0);
    stall_wb = 1'b0;
    tick();
    nop();
    #1;
    chk("ldb_idle_req", {31'h0, dbus_req}, 32'h0);

    // LD_W: addr_ok on 4th request cycle, data_ok two cycles after.
    tick();
    rc = 0;
    issue(OP_LD_W, 32'h0000_1004);
    for (int k = 0; k < 4; k++) begin
      dbus_addr_ok = (k == 3);
      #1;
      rc += int'(dbus_req);
      chk($sformatf("ldw_stall_req%0d", k), {31'h0, stallreq_mem}, 32'h1);
      tick();
    end
    dbus_addr_ok = 1'b0;
    for (int k = 0; k < 2; k++) begin
      dbus_data_ok = (k == 1);
      dbus_rdata = 32'hCAFE_F00D;
      #1;
      rc += int'(dbus_req);
      chk($sformatf("ldw_stall_wait%0d", k), {31'h0, stallreq_mem}, 32'h1);
      tick();
    end
    dbus_data_ok = 1'b0;
    #1;
    chk("ldw_req_cycles", rc, 4);
    chk("ldw_done_stall", {31'h0, stallreq_mem}, 32'h0);
    chk("ldw_wdata", wb_wdata, 32'hCAFE_F00D);
    tick();
    nop();

    // Flush in WAIT, then LD_HU must wait for the stale response.
    tick();
    issue(OP_LD_W, 32'h0000_1008); dbus_addr_ok = 1'b1;
    tick();
    dbus_addr_ok = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    issue(OP_LD_HU, 32'h0000_100A);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("drain_req%0d", k), {31'h0, dbus_req}, 32'h0);
      chk($sformatf("drain_stall%0d", k), {31'h0, stallreq_mem}, 32'h1);
      tick();
    end
    dbus_data_ok = 1'b1; dbus_rdata = 32'hDEAD_1111;
    #1;
    chk("drain_stale_req", {31'h0, dbus_req}, 32'h0);
    tick();
    dbus_data_ok = 1'b0; dbus_addr_ok = 1'b1;
    #1;
    chk("drain_reissue_req", {31'h0, dbus_req}, 32'h1);
    tick();
    dbus_addr_ok = 1'b0; dbus_data_ok = 1'b1; dbus_rdata = 32'h8765_4321;
    tick();
    dbus_data_ok = 1'b0;
    #1;
    chk("ldhu_wdata", wb_wdata, 32'h0000_8765);
    chk("ldhu_stall", {31'h0, stallreq_mem}, 32'h0);
    tick();
    nop();

    // Synchronous reset while waiting for data.
    tick();
    issue(OP_LD_W, 32'h0000_100C); dbus_addr_ok = 1'b1;
    tick();
    nop();
    #1;
    chk("rst_wait_stall", {31'h0, stallreq_mem}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_after_req", {31'h0, dbus_req}, 32'h0);
    chk("rst_after_stall", {31'h0, stallreq_mem}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
